// File: rtl/avr_boot_pkg.sv
// avr_boot_pkg: boot FSM state encoding, SPI flash opcodes and address byte selection.
package avr_boot_pkg;

   typedef enum logic [2:0] {WAKE_CMD, WAKE_WAIT, READ_CMD, READ_DATA, DONE} boot_state_e;

   localparam logic [7:0] CMD_WAKE = 8'hAB;
   localparam logic [7:0] CMD_READ = 8'h03;

   // idx 0..2 selects the address bytes in transmit order (MSB first)
   function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] idx);
      return idx == 2'd0 ? addr[23:16] : idx == 2'd1 ? addr[15:8] : addr[7:0];
   endfunction

endpackage

// File: rtl/spi_shift8.sv
// spi_shift8: mode-0 SPI byte engine with SCK divider; mosi shifts on falling SCK, miso sampled on rising SCK.
module spi_shift8 #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clr_i,
   input  logic       start_i,
   input  logic [7:0] tx_i,
   input  logic       miso_i,
   output logic       sck_o,
   output logic       mosi_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] rx_o
);

   logic       busy_q, busy_d, sck_q, sck_d, done_q, done_d;
   logic [7:0] div_q, div_d, tx_q, tx_d, rx_q, rx_d;
   logic [2:0] bit_q, bit_d;
   logic       tick;

   assign tick = div_q == 8'(CLK_DIV - 1);

   always_comb begin
      busy_d = busy_q;
      sck_d  = sck_q;
      done_d = 1'b0;
      div_d  = div_q;
      tx_d   = tx_q;
      rx_d   = rx_q;
      bit_d  = bit_q;
      if (clr_i) begin
         busy_d = 1'b0;
         sck_d  = 1'b0;
         div_d  = 8'd0;
         tx_d   = 8'd0;
      end else if (start_i && !busy_q) begin
         busy_d = 1'b1;
         tx_d   = tx_i;
         div_d  = 8'd0;
         bit_d  = 3'd0;
      end else if (busy_q) begin
         div_d = tick ? 8'd0 : div_q + 8'd1;
         if (tick && !sck_q) begin
            sck_d = 1'b1;
            rx_d  = {rx_q[6:0], miso_i};
         end else if (tick) begin
            // falling edge: present next bit; after 8 shifts tx is zero so mosi idles low
            sck_d  = 1'b0;
            tx_d   = {tx_q[6:0], 1'b0};
            bit_d  = bit_q + 3'd1;
            busy_d = bit_q != 3'd7;
            done_d = bit_q == 3'd7;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q <= 1'b0;
         sck_q  <= 1'b0;
         done_q <= 1'b0;
         div_q  <= 8'd0;
         tx_q   <= 8'd0;
         rx_q   <= 8'd0;
         bit_q  <= 3'd0;
      end else begin
         busy_q <= busy_d;
         sck_q  <= sck_d;
         done_q <= done_d;
         div_q  <= div_d;
         tx_q   <= tx_d;
         rx_q   <= rx_d;
         bit_q  <= bit_d;
      end
   end

   assign sck_o  = sck_q;
   assign mosi_o = tx_q[7];
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign rx_o   = rx_q;

endmodule

// File: rtl/avr_flash_boot.sv
// avr_flash_boot: wakes the SPI flash, streams the program image into program memory
// and holds the AVR core in reset until the whole image is loaded.
module avr_flash_boot
   import avr_boot_pkg::*;
#(
   parameter int          WORDS       = 1024,
   parameter logic [23:0] FLASH_ADDR  = 24'h100000,
   parameter int          CLK_DIV     = 2,
   parameter int          WAKE_CYCLES = 256,
   localparam int         AW          = WORDS > 1 ? $clog2(WORDS) : 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          reboot,
   output logic          spi_cs,
   output logic          spi_sck,
   output logic          spi_mosi,
   input  logic          spi_miso,
   output logic          pmem_wr_en,
   output logic [AW-1:0] pmem_wr_addr,
   output logic [15:0]   pmem_wr_data,
   output logic          cpu_reset,
   output logic          boot_done
);

   boot_state_e   state_q;
   logic [15:0]   cnt_q;
   logic          phase_q, start_q, cs_q, hi_q, wr_en_q, cpu_reset_q, boot_done_q;
   logic [7:0]    tx_q, lo_q;
   logic [AW-1:0] word_q, wr_addr_q;
   logic [15:0]   wr_data_q;
   logic          busy, done;
   logic [7:0]    rx;

   spi_shift8 #(.CLK_DIV(CLK_DIV)) u_shift (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (reboot),
      .start_i (start_q),
      .tx_i    (tx_q),
      .miso_i  (spi_miso),
      .sck_o   (spi_sck),
      .mosi_o  (spi_mosi),
      .busy_o  (busy),
      .done_o  (done),
      .rx_o    (rx)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= WAKE_CMD;
         cnt_q       <= 16'd0;
         phase_q     <= 1'b0;
         start_q     <= 1'b0;
         cs_q        <= 1'b1;
         hi_q        <= 1'b0;
         tx_q        <= 8'd0;
         lo_q        <= 8'd0;
         word_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 16'd0;
         cpu_reset_q <= 1'b1;
         boot_done_q <= 1'b0;
      end else if (reboot) begin
         state_q     <= WAKE_CMD;
         cnt_q       <= 16'd0;
         phase_q     <= 1'b0;
         start_q     <= 1'b0;
         cs_q        <= 1'b1;
         hi_q        <= 1'b0;
         word_q      <= '0;
         wr_en_q     <= 1'b0;
         cpu_reset_q <= 1'b1;
         boot_done_q <= 1'b0;
      end else begin
         start_q <= 1'b0;
         wr_en_q <= 1'b0;
         unique case (state_q)
            WAKE_CMD: begin
               // phase 0 keeps CS high for CLK_DIV cycles so a reboot never glues two frames together
               if (!phase_q) begin
                  if (cnt_q == 16'(CLK_DIV - 1) && !busy) begin
                     cs_q    <= 1'b0;
                     start_q <= 1'b1;
                     tx_q    <= CMD_WAKE;
                     phase_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 16'd1;
                  end
               end else if (done) begin
                  cs_q    <= 1'b1;
                  phase_q <= 1'b0;
                  cnt_q   <= 16'd0;
                  state_q <= WAKE_WAIT;
               end
            end
            WAKE_WAIT: begin
               if (cnt_q == 16'(WAKE_CYCLES - 1)) begin
                  cs_q    <= 1'b0;
                  start_q <= 1'b1;
                  tx_q    <= CMD_READ;
                  cnt_q   <= 16'd0;
                  state_q <= READ_CMD;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            READ_CMD: begin
               if (done) begin
                  start_q <= 1'b1;
                  cnt_q   <= cnt_q + 16'd1;
                  tx_q    <= cnt_q == 16'd3 ? 8'h00 : addr_byte(FLASH_ADDR, cnt_q[1:0]);
                  if (cnt_q == 16'd3)
                     state_q <= READ_DATA;
               end
            end
            READ_DATA: begin
               // the final write completes one cycle before cpu_reset drops
               if (wr_en_q && wr_addr_q == AW'(WORDS - 1)) begin
                  cs_q        <= 1'b1;
                  cpu_reset_q <= 1'b0;
                  boot_done_q <= 1'b1;
                  state_q     <= DONE;
               end else if (done && !hi_q) begin
                  lo_q    <= rx;
                  hi_q    <= 1'b1;
                  start_q <= 1'b1;
               end else if (done) begin
                  hi_q      <= 1'b0;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= word_q;
                  wr_data_q <= {rx, lo_q};
                  word_q    <= word_q + 1'b1;
                  start_q   <= word_q != AW'(WORDS - 1);
               end
            end
            DONE: begin
               cs_q <= 1'b1;
            end
            default: state_q <= WAKE_CMD;
         endcase
      end
   end

   assign spi_cs       = cs_q;
   assign pmem_wr_en   = wr_en_q;
   assign pmem_wr_addr = wr_addr_q;
   assign pmem_wr_data = wr_data_q;
   assign cpu_reset    = cpu_reset_q;
   assign boot_done    = boot_done_q;

endmodule

// File: tb/tb_avr_flash_boot.sv
// tb_avr_flash_boot: scoreboard bench for avr_flash_boot with a behavioural SPI flash model
// at CLK_DIV=1 (functional, reboot, reset) and CLK_DIV=3 (SCK timing).
module tb_avr_flash_boot;

   localparam int WAKE = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n = 1'b1, rst3_n = 1'b1, reboot = 1'b0, reboot3 = 1'b0;
   logic cs, sck, mosi, miso = 1'b0, wr_en, cpu_reset, boot_done;
   logic cs3, sck3, mosi3, miso3 = 1'b0, wr3, cpu_reset3, boot_done3;
   logic [1:0]  wr_addr, wr_addr3;
   logic [15:0] wr_data, wr_data3;

   avr_flash_boot #(.WORDS(4), .CLK_DIV(1), .WAKE_CYCLES(WAKE)) dut (
      .clk(clk), .reset_n(reset_n), .reboot(reboot), .spi_cs(cs), .spi_sck(sck), .spi_mosi(mosi),
      .spi_miso(miso), .pmem_wr_en(wr_en), .pmem_wr_addr(wr_addr), .pmem_wr_data(wr_data),
      .cpu_reset(cpu_reset), .boot_done(boot_done));

   avr_flash_boot #(.WORDS(4), .CLK_DIV(3), .WAKE_CYCLES(WAKE)) dut3 (
      .clk(clk), .reset_n(rst3_n), .reboot(reboot3), .spi_cs(cs3), .spi_sck(sck3), .spi_mosi(mosi3),
      .spi_miso(miso3), .pmem_wr_en(wr3), .pmem_wr_addr(wr_addr3), .pmem_wr_data(wr_data3),
      .cpu_reset(cpu_reset3), .boot_done(boot_done3));

   logic [7:0]  img   [8] = '{8'h0C, 8'h94, 8'h34, 8'h12, 8'hFF, 8'hCF, 8'h00, 8'h00};
   logic [15:0] exp_d [4] = '{16'h940C, 16'h1234, 16'hCFFF, 16'h0000};

   int tests = 0, fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic img_bit(input int k);
      logic [7:0] b;
      if (k >= 64) return 1'b0;
      b = img[k / 8];
      return b[7 - (k % 8)];
   endfunction

   // flash model for dut: records each CS-low frame (first 32 MOSI bits) and serves the image
   int bits = 0, fbits[$];
   logic [31:0] sh = 0, fword[$];
   time t_lo = 0, fstart[$], fend[$];

   always @(negedge cs) begin bits = 0; sh = 0; miso = 1'b0; t_lo = $time; end
   always @(posedge cs) if (bits > 0) begin
      fbits.push_back(bits); fword.push_back(sh); fstart.push_back(t_lo); fend.push_back($time); bits = 0;
   end
   always @(posedge sck) if (!cs) begin if (bits < 32) sh = {sh[30:0], mosi}; bits++; end
   always @(negedge sck) if (!cs && bits >= 32 && sh[31:24] == 8'h03) miso = img_bit(bits - 32);

   // flash model for dut3 with SCK period/high-time measurement
   int bits3 = 0, p3_n = 0, p3_bad = 0, h3_bad = 0, n3 = 0;
   logic [31:0] sh3 = 0;
   time tr3 = 0;
   logic [15:0] w3 [4];

   always @(negedge cs3) begin bits3 = 0; sh3 = 0; miso3 = 1'b0; end
   always @(posedge sck3) if (!cs3) begin
      if (bits3 % 8 != 0 && $time - tr3 != 60) p3_bad++;
      tr3 = $time; p3_n++;
      if (bits3 < 32) sh3 = {sh3[30:0], mosi3};
      bits3++;
   end
   always @(negedge sck3) if (!cs3) begin
      if ($time - tr3 != 30) h3_bad++;
      if (bits3 >= 32 && sh3[31:24] == 8'h03) miso3 = img_bit(bits3 - 32);
   end

   // scoreboard monitor
   typedef struct { logic [1:0] a; logic [15:0] d; } wr_t;
   wr_t exp_q[$];
   int ld_wr = 0, strobe_bad = 0, sck_bad = 0;
   logic wr_prev = 1'b0;

   always @(negedge clk) begin
      wr_t e;
      if (wr_en) begin
         ld_wr++;
         if (!cpu_reset || wr_prev) strobe_bad++;
         if (exp_q.size() == 0) check("unexpected_write", {14'd0, wr_addr, wr_data}, 32'hFFFFFFFF);
         else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e.a));
            check("wr_data", 32'(wr_data), 32'(e.d));
         end
      end
      wr_prev = wr_en;
      if ((cs && sck) || (cs3 && sck3)) sck_bad++;
      if (wr3) begin w3[wr_addr3] = wr_data3; n3++; end
   end

   task automatic push_load();
      for (int i = 0; i < 4; i++) exp_q.push_back('{a: 2'(i), d: exp_d[i]});
      ld_wr = 0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (!boot_done && n < budget) begin @(posedge clk); n++; end
      #1 check(name, 32'(boot_done), 32'd1);
   endtask

   task automatic wait_wr(input int k, input int budget);
      int n = 0;
      while (ld_wr < k && n < budget) begin @(negedge clk); n++; end
      check("write_progress", 32'(ld_wr >= k), 32'd1);
   endtask

   task automatic check_idle_reset(input string tag);
      check({tag, "_cs"}, 32'(cs), 32'd1);
      check({tag, "_sck"}, 32'(sck), 32'd0);
      check({tag, "_mosi"}, 32'(mosi), 32'd0);
      check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
      check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
      check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
      check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
      check({tag, "_boot_done"}, 32'(boot_done), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nf, n;
      #1 reset_n = 1'b0; rst3_n = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_reset("reset");
      push_load();
      reset_n = 1'b1; rst3_n = 1'b1;
      wait_done("load1_done", 2000);
      @(negedge clk);
      check("load1_cpu_reset", 32'(cpu_reset), 32'd0);
      check("load1_cs_idle", 32'(cs), 32'd1);
      check("load1_writes", 32'(ld_wr), 32'd4);
      check("load1_queue_empty", 32'(exp_q.size()), 32'd0);
      check("frame_count", 32'(fbits.size()), 32'd2);
      if (fbits.size() >= 2) begin
         check("wake_frame", fword[0], 32'h000000AB);
         check("wake_bits", 32'(fbits[0]), 32'd8);
         check("read_frame", fword[1], 32'h03100000);
         check("read_bits", 32'(fbits[1]), 32'd96);
         check("cs_gap_cycles", 32'((fstart[1] - fend[0]) / 10), 32'(WAKE));
      end
      repeat (20) @(negedge clk);
      check("no_extra_writes", 32'(ld_wr), 32'd4);

      n = 0;
      while (!boot_done3 && n < 5000) begin @(negedge clk); n++; end
      check("div3_done", 32'(boot_done3), 32'd1);
      check("div3_cpu_reset", 32'(cpu_reset3), 32'd0);
      check("div3_writes", 32'(n3), 32'd4);
      for (int i = 0; i < 4; i++) check("div3_word", 32'(w3[i]), 32'(exp_d[i]));
      check("div3_sck_rises", 32'(p3_n), 32'd104);
      check("div3_period_bad", 32'(p3_bad), 32'd0);
      check("div3_high_bad", 32'(h3_bad), 32'd0);

      nf = fbits.size();
      reboot = 1'b1; push_load();
      @(negedge clk) reboot = 1'b0;
      check("reboot_cpu_reset", 32'(cpu_reset), 32'd1);
      check("reboot_boot_done", 32'(boot_done), 32'd0);
      check("reboot_cs", 32'(cs), 32'd1);
      check("reboot_sck", 32'(sck), 32'd0);
      wait_wr(1, 2000);
      repeat (3) @(negedge clk);
      reboot = 1'b1; exp_q.delete(); push_load();
      @(negedge clk) reboot = 1'b0;
      check("reboot2_cs", 32'(cs), 32'd1);
      check("reboot2_sck", 32'(sck), 32'd0);
      wait_done("reload_done", 2000);
      @(negedge clk);
      check("reload_writes", 32'(ld_wr), 32'd4);
      check("reload_queue_empty", 32'(exp_q.size()), 32'd0);
      check("reload_frames", 32'(fbits.size()), 32'(nf + 4));
      if (fbits.size() >= 2) begin
         check("reload_wake_frame", fword[fbits.size() - 2], 32'h000000AB);
         check("reload_read_frame", fword[fbits.size() - 1], 32'h03100000);
      end

      reboot = 1'b1; push_load();
      @(negedge clk) reboot = 1'b0;
      wait_wr(2, 2000);
      repeat (4) @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check_idle_reset("async_rst");
      exp_q.delete(); push_load();
      @(negedge clk) reset_n = 1'b1;
      wait_done("after_reset_done", 2000);
      @(negedge clk);
      check("after_reset_writes", 32'(ld_wr), 32'd4);
      check("after_reset_queue_empty", 32'(exp_q.size()), 32'd0);
      check("strobe_violations", 32'(strobe_bad), 32'd0);
      check("sck_while_cs_high", 32'(sck_bad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/avr_flash_boot.md
AVR_FLASH_BOOT -- requirements
Module: avr_flash_boot

Interface
REQ-001 Parameter WORDS, default 1024, number of 16-bit program words to load.
REQ-002 Parameter FLASH_ADDR, default 24'h100000, byte offset of the program image in SPI flash.
REQ-003 Parameter CLK_DIV, default 2, clk cycles per SCK half-period (range 1..255).
REQ-004 Parameter WAKE_CYCLES, default 256, clk cycles of CS-high wait after the wake command.
REQ-005 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-006 reset_n  input  1  reset; asynchronous and active-low.
REQ-007 reboot  input  1  single-cycle request to reload the program and restart the CPU.
REQ-008 spi_cs  output  1  flash chip select, active-low.
REQ-009 spi_sck  output  1  SPI clock, mode 0 (idles low).
REQ-010 spi_mosi  output  1  serial data to flash, MSB first.
REQ-011 spi_miso  input  1  serial data from flash.
REQ-012 pmem_wr_en  output  1  one-cycle program-memory write strobe.
REQ-013 pmem_wr_addr  output  clog2(WORDS)  word address of the write.
REQ-014 pmem_wr_data  output  16  instruction word written.
REQ-015 cpu_reset  output  1  active-high reset to the avr_soc; asserted whenever loading.
REQ-016 boot_done  output  1  high once the full image is loaded, until the next reboot/reset.

Function
REQ-017 States SHALL be: WAKE_CMD, WAKE_WAIT, READ_CMD, READ_DATA, DONE; first state after reset release is WAKE_CMD.
REQ-018 WAKE_CMD: spi_cs low, shift out 8'hAB (release power-down), then spi_cs high -> WAKE_WAIT.
REQ-019 WAKE_WAIT: spi_cs high for exactly WAKE_CYCLES clk cycles -> READ_CMD.
REQ-020 READ_CMD: spi_cs low, shift out 8'h03 then FLASH_ADDR[23:0] MSB first (32 bits total) -> READ_DATA with spi_cs held low.
REQ-021 SCK timing: each half-period = CLK_DIV clk cycles; mosi changes only while sck low; miso sampled on the clk cycle sck rises.
REQ-022 READ_DATA: bytes arrive MSB first; first byte of each pair = pmem_wr_data[7:0], second = [15:8] (AVR little-endian).
REQ-023 pmem_wr_en SHALL pulse for one cycle on the clk after the 16th bit of a word is sampled, with addr = word index 0..WORDS-1 incrementing by 1.
REQ-024 After the write of address WORDS-1: next cycle spi_cs high, sck low, state DONE.
REQ-025 DONE: cpu_reset low, boot_done high, SPI pins idle, no further writes.
REQ-026 cpu_reset SHALL be high in every state except DONE.
REQ-027 reboot in any state SHALL, next cycle, force spi_cs high, sck low, cpu_reset high, boot_done low, clear word counter, and enter WAKE_CMD; reboot mid-byte discards the partial word.
REQ-028 spi_cs SHALL be high for at least CLK_DIV clk cycles between any two CS-low frames.

Reset
REQ-029 While reset_n low: spi_cs=1, spi_sck=0, spi_mosi=0, pmem_wr_en=0, pmem_wr_addr=0, pmem_wr_data=0, cpu_reset=1, boot_done=0, state WAKE_CMD, all counters 0.
REQ-030 reset_n asserted mid-transfer SHALL abort immediately (asynchronously) with the values of REQ-029; the load restarts from word 0 on release.

Structure
REQ-031 Package avr_boot_pkg SHALL hold the state enum and constants CMD_WAKE=8'hAB, CMD_READ=8'h03.
REQ-032 Sub-module spi_shift8 SHALL implement the divider and 8-bit mode-0 shift (load byte, start, busy, done pulse, rx byte); the FSM sequences it.

Verification
REQ-033 WORDS=4, CLK_DIV=1, flash model image 0C 94 34 12 FF CF 00 00 -> writes (0,16'h940C),(1,16'h1234),(2,16'hCFFF),(3,16'h0000), then boot_done=1, cpu_reset=0.
REQ-034 MOSI decode -> frame 1 = AB; frame 2 = 03 10 00 00; CS-high gap between frames = WAKE_CYCLES clk cycles.
REQ-035 CLK_DIV=3 -> SCK period = 6 clk cycles, sck low whenever spi_cs high, miso sampled only on rising sck.
REQ-036 reset_n low during word 2 -> outputs match REQ-029 within the same cycle; after release writes restart at address 0.
REQ-037 reboot pulse in DONE and again mid-READ_DATA -> cpu_reset high next cycle, new AB frame, full 4-word reload, no write to address beyond 3.
REQ-038 Write-strobe check -> exactly WORDS single-cycle pmem_wr_en pulses per load, never while cpu_reset=0.
